// File: rtl/mac_array_os.sv
// Output-stationary ROW x COL signed MAC array computing C = A x B.
// Operands arrive unskewed (one k-slice per cycle) and are skewed internally;
// each PE holds C[i][j] in place and results drain one row per cycle.
// Optional feature macro: MAC_ARRAY_SAT_EN (saturating accumulation).
module mac_array_os #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_W   = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [LEN_W-1:0]                              len,
    input  logic [ROW*BW-1:0]                             in_w,
    input  logic [COL*BW-1:0]                             in_n,
    output logic                                          in_ready,
    output logic                                          busy,
    output logic [COL*PSUM_BW-1:0]                        out_s,
    output logic [((ROW > 1) ? $clog2(ROW) : 1)-1:0]      out_row,
    output logic                                          out_valid,
    output logic                                          done
);

    localparam int RW     = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int FCW    = (ROW + COL > 1) ? $clog2(ROW + COL) : 1;
    localparam int CNT_W  = (LEN_W > FCW) ? LEN_W : FCW;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t               state, state_nx;
    logic [LEN_W-1:0]     len_q;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     load_last;
    logic [CNT_W-1:0]     flush_last;
    logic [RW-1:0]        drow;
    logic                 accept;
    logic                 mac_en;
    logic [COL*PSUM_BW-1:0] row_sel;

    logic signed [BW-1:0]      a_in [ROW][COL];
    logic signed [BW-1:0]      b_in [ROW][COL];
    logic signed [PSUM_BW-1:0] acc  [ROW][COL];

    // Accumulator add: two's-complement wrap, or clamp to the rails when enabled.
    function automatic logic signed [PSUM_BW-1:0] sat_add(
        input logic signed [PSUM_BW-1:0] x,
        input logic signed [PSUM_BW-1:0] y
    );
`ifdef MAC_ARRAY_SAT_EN
        logic [PSUM_BW:0] wide;
        wide = {x[PSUM_BW-1], x} + {y[PSUM_BW-1], y};
        if (wide[PSUM_BW] != wide[PSUM_BW-1])
            sat_add = wide[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                    : {1'b0, {(PSUM_BW-1){1'b1}}};
        else
            sat_add = wide[PSUM_BW-1:0];
`else
        sat_add = x + y;
`endif
    endfunction

    // Full-width signed product, sign-extended into the accumulator width.
    function automatic logic signed [PSUM_BW-1:0] mac(
        input logic signed [PSUM_BW-1:0] acc_in,
        input logic signed [BW-1:0]      a,
        input logic signed [BW-1:0]      b
    );
        logic signed [2*BW-1:0] prod;
        prod = (2*BW)'(a) * (2*BW)'(b);
        mac  = sat_add(acc_in, PSUM_BW'(prod));
    endfunction

    assign accept     = (state == IDLE) && start && (len != '0);
    assign mac_en     = (state == LOAD) || (state == FLUSH);
    assign in_ready   = (state == LOAD);
    assign busy       = (state != IDLE);
    assign load_last  = CNT_W'(len_q) - CNT_W'(1);
    assign flush_last = CNT_W'(ROW + COL - 2);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic: LOAD for len cycles, FLUSH until the corner PE finishes, DRAIN ROW rows.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    if (cnt == load_last) state_nx = FLUSH;
            FLUSH:   if (cnt == flush_last) state_nx = DRAIN;
            DRAIN:   if (drow == RW'(ROW - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Phase counter restarts on every state change; len is captured at job acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            len_q <= '0;
        end else begin
            if (accept)
                len_q <= len;
            if (state != state_nx)
                cnt <= '0;
            else if (mac_en)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Drain row pointer advances once per DRAIN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drow <= '0;
        else if (state == DRAIN)
            drow <= drow + RW'(1);
        else
            drow <= '0;
    end

    genvar gi, gj;

    // West-edge skew: row i sees its A value i cycles late.
    for (gi = 0; gi < ROW; gi++) begin : g_skew_w
        logic signed [BW-1:0] dl [0:gi];
        // Delay line with zero injection outside LOAD.
        always_ff @(posedge clk or posedge reset) begin
            if (reset || accept) begin
                for (int d = 0; d <= gi; d++) dl[d] <= '0;
            end else begin
                dl[0] <= in_ready ? $signed(in_w[gi*BW +: BW]) : '0;
                for (int d = 1; d <= gi; d++) dl[d] <= dl[d-1];
            end
        end
        assign a_in[gi][0] = dl[gi];
    end

    // North-edge skew: column j sees its B value j cycles late.
    for (gj = 0; gj < COL; gj++) begin : g_skew_n
        logic signed [BW-1:0] dl [0:gj];
        // Delay line with zero injection outside LOAD.
        always_ff @(posedge clk or posedge reset) begin
            if (reset || accept) begin
                for (int d = 0; d <= gj; d++) dl[d] <= '0;
            end else begin
                dl[0] <= in_ready ? $signed(in_n[gj*BW +: BW]) : '0;
                for (int d = 1; d <= gj; d++) dl[d] <= dl[d-1];
            end
        end
        assign b_in[0][gj] = dl[gj];
    end

    // PE grid: each PE accumulates in place and forwards A east and B south.
    for (gi = 0; gi < ROW; gi++) begin : g_row
        for (gj = 0; gj < COL; gj++) begin : g_pe
            logic signed [PSUM_BW-1:0] acc_q;

            // Stationary accumulator, cleared when a job is accepted.
            always_ff @(posedge clk or posedge reset) begin
                if (reset || accept)
                    acc_q <= '0;
                else if (mac_en)
                    acc_q <= mac(acc_q, a_in[gi][gj], b_in[gi][gj]);
            end
            assign acc[gi][gj] = acc_q;

            if (gj < COL - 1) begin : g_east
                logic signed [BW-1:0] a_q;
                // Forward A one PE east per cycle.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset || accept)
                        a_q <= '0;
                    else
                        a_q <= a_in[gi][gj];
                end
                assign a_in[gi][gj+1] = a_q;
            end

            if (gi < ROW - 1) begin : g_south
                logic signed [BW-1:0] b_q;
                // Forward B one PE south per cycle.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset || accept)
                        b_q <= '0;
                    else
                        b_q <= b_in[gi][gj];
                end
                assign b_in[gi+1][gj] = b_q;
            end
        end
    end

    // Row-select mux feeding the registered output.
    always_comb begin
        row_sel = '0;
        for (int j = 0; j < COL; j++)
            row_sel[j*PSUM_BW +: PSUM_BW] = acc[drow][j];
    end

    // Registered drain outputs; data holds while out_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_s     <= '0;
            out_row   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= (state == DRAIN);
            done      <= (state == DRAIN) && (drow == RW'(ROW - 1));
            if (state == DRAIN) begin
                out_s   <= row_sel;
                out_row <= drow;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_os.sv
// Directed bench for mac_array_os: table of constant-operand jobs plus
// hand-written identity, wrap/saturate, perturbation and reset sequences.
module tb_mac_array_os;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   len;
    logic [31:0]  in_w, in_n;
    logic         in_ready, busy, out_valid, done;
    logic [127:0] out_s;
    logic [2:0]   out_row;

    logic         start_s;
    logic [7:0]   len_s;
    logic [7:0]   in_w_s, in_n_s;
    logic         ready_s, busy_s, valid_s, done_s;
    logic [15:0]  out_s_s;
    logic [0:0]   row_s;

    int total = 0;
    int bad   = 0;

    logic signed [3:0] mat_a [0:7][0:255];
    logic signed [3:0] mat_b [0:255][0:7];
    int                expc  [0:7][0:7];

    typedef struct {
        int n;
        int a;
        int b;
        int c;
    } vec_t;
    vec_t vecs [6];

    mac_array_os u_dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_w(in_w), .in_n(in_n), .in_ready(in_ready), .busy(busy),
        .out_s(out_s), .out_row(out_row), .out_valid(out_valid), .done(done)
    );

    mac_array_os #(.BW(4), .PSUM_BW(8), .ROW(2), .COL(2), .LEN_W(8)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .len(len_s),
        .in_w(in_w_s), .in_n(in_n_s), .in_ready(ready_s), .busy(busy_s),
        .out_s(out_s_s), .out_row(row_s), .out_valid(valid_s), .done(done_s)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic fill_const(input int a, input int b, input int c);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 256; k++) begin
                mat_a[i][k] = 4'(a);
                mat_b[k][i] = 4'(b);
            end
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                expc[r][j] = c;
    endtask

    task automatic run_job(input int n, input bit perturb, input string tag);
        int ready_cnt = 0;
        int ready_err = 0;
        int ctl_err   = 0;
        int r;
        @(negedge clk);
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk);
        for (int t = 0; t <= n + 25; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (perturb && (t == 1 || t == n + 18)) begin
                start = 1'b1;
                len   = 8'd5;
            end
            if (in_ready) ready_cnt++;
            if (in_ready !== (t < n)) ready_err++;
            if (out_valid !== (t >= n + 16 && t <= n + 23)) ctl_err++;
            if (done !== (t == n + 23)) ctl_err++;
            if (t != n + 23 && busy !== (t < n + 23)) ctl_err++;
            if (t >= n + 16 && t <= n + 23) begin
                r = t - n - 16;
                check($sformatf("%s_row_index_%0d", tag, r), int'(out_row), r);
                for (int j = 0; j < 8; j++)
                    check($sformatf("%s_c%0d%0d", tag, r, j),
                          int'($signed(out_s[j*16 +: 16])), expc[r][j]);
            end
            for (int i = 0; i < 8; i++) begin
                in_w[i*4 +: 4] = (t < n) ? mat_a[i][t] : 4'($urandom);
                in_n[i*4 +: 4] = (t < n) ? mat_b[t][i] : 4'($urandom);
            end
        end
        check({tag, "_in_ready_count"}, ready_cnt, n);
        check({tag, "_in_ready_pattern_errs"}, ready_err, 0);
        check({tag, "_control_timing_errs"}, ctl_err, 0);
        check({tag, "_hold_row"}, int'(out_row), 7);
        check({tag, "_hold_data"}, int'($signed(out_s[127 -: 16])), expc[7][7]);
    endtask

    initial begin
        int first_t;
        int rows;
        int exp_small;

        vecs[0] = '{n: 1,   a: 3,  b: 2,  c: 6};
        vecs[1] = '{n: 4,   a: -1, b: 5,  c: -20};
        vecs[2] = '{n: 255, a: -8, b: -8, c: 16320};
        vecs[3] = '{n: 3,   a: 7,  b: -8, c: -168};
        vecs[4] = '{n: 2,   a: -8, b: 7,  c: -112};
        vecs[5] = '{n: 5,   a: -3, b: -4, c: 60};

        reset = 1'b1; start = 1'b0; len = '0; in_w = '0; in_n = '0;
        start_s = 1'b0; len_s = '0; in_w_s = '0; in_n_s = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_out_s_nonzero", int'(out_s != '0), 0);
        check("reset_out_row", int'(out_row), 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            fill_const(vecs[v].a, vecs[v].b, vecs[v].c);
            run_job(vecs[v].n, 1'b0, $sformatf("vec%0d", v));
        end

        // start with len=0 in IDLE must be ignored
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy", int'(busy), 0);
        check("len0_in_ready", int'(in_ready), 0);

        // rerun a table job with start pulses during LOAD/FLUSH and DRAIN
        fill_const(3, 2, 6);
        run_job(1, 1'b1, "perturb_len1");
        fill_const(-1, 5, -20);
        run_job(4, 1'b1, "perturb_len4");

        // identity A, B[k][j] = k-j: each result row equals B row r
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                mat_a[i][k] = (i == k) ? 4'sd1 : 4'sd0;
                mat_b[i][k] = 4'(i - k);
            end
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                expc[r][j] = r - j;
        run_job(8, 1'b0, "identity");

        // narrow accumulator: 4 x (7*7) = 196 wraps to -60, or clamps to 127
`ifdef MAC_ARRAY_SAT_EN
        exp_small = 127;
`else
        exp_small = -60;
`endif
        @(negedge clk);
        start_s = 1'b1; len_s = 8'd4; in_w_s = 8'h77; in_n_s = 8'h77;
        @(posedge clk);
        first_t = -1;
        rows = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (valid_s) begin
                if (first_t < 0) first_t = t;
                check($sformatf("small_row_index_%0d", rows), int'(row_s), rows);
                check($sformatf("small_r%0d_c0", rows), int'($signed(out_s_s[7:0])), exp_small);
                check($sformatf("small_r%0d_c1", rows), int'($signed(out_s_s[15:8])), exp_small);
                rows++;
            end
        end
        check("small_rows", rows, 2);
        check("small_latency", first_t, 8);

        // reset during FLUSH of a len=8 job
        fill_const(2, 3, 0);
        @(negedge clk);
        start = 1'b1; len = 8'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_done", int'(done), 0);
        check("abort_out_s_nonzero", int'(out_s != '0), 0);
        check("abort_out_row", int'(out_row), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_abort_busy", int'(busy), 0);
        check("post_abort_out_valid", int'(out_valid), 0);
        fill_const(1, -1, -1);
        run_job(1, 1'b0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_array_os.md
# mac_array_os

Output-stationary, fully parametrised successor to the weight-stationary MAC array. It computes C = A x B, where A is ROW x LEN and B is LEN x COL, with signed BW-bit operands. Operands enter unskewed, one k-slice per cycle, and the block skews them internally. Each PE(i,j) keeps C[i][j] in place, and the results drain one row per cycle to the output-buffer/SFU stage.

## Interface
Parameters:
- BW, 4: operand width, signed two's complement.
- PSUM_BW, 16: accumulator and output width, signed.
- ROW, 8: PE rows, ≥1.
- COL, 8: PE columns, ≥1.
- LEN_W, 8: width of the k-length field.

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; returns block to IDLE and clears all state.
- start  in  1  request a new matrix product; sampled only in IDLE.
- len  in  LEN_W  K dimension; latched when start is accepted.
- in_w  in  ROW*BW  A column k; slice i = A[i][k].
- in_n  in  COL*BW  B row k; slice j = B[k][j].
- in_ready  out  1  block samples in_w/in_n this cycle.
- busy  out  1  high from start acceptance until drain completes.
- out_s  out  COL*PSUM_BW  result row; slice j = C[r][j]; registered.
- out_row  out  clog2(ROW) (min 1)  row index r of out_s.
- out_valid  out  1  out_s/out_row hold a valid row.
- done  out  1  single-cycle pulse, coincident with the last out_valid.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE → LOAD: start=1 and len≠0 at edge S. This edge latches len, clears every accumulator and skew register, and sets busy.
- start with len=0 is ignored. start outside IDLE is ignored.
- LOAD: in_ready=1 for exactly len cycles. Element k is sampled at edge S+1+k, for k in 0..len-1.
- Skew: row i input delays i cycles, column j input delays j cycles. A values move one PE east per cycle; B values move one PE south per cycle. Zeros are injected whenever in_ready=0.
- PE(i,j) performs acc += A[i][k]*B[k][j] at edge S+2+k+i+j.
- Product is the full 2*BW signed result, sign-extended to PSUM_BW. Accumulation wraps modulo 2^PSUM_BW unless saturation is enabled (see Configuration).
- FLUSH: lasts until the final accumulate at edge S+len+ROW+COL-1.
- DRAIN: ROW cycles. Output rows 0..ROW-1 appear in ascending order, one per cycle. Draining uses a row-select mux or a south shift, at implementer's choice; observable order is fixed.
- After the last row: done pulses, busy falls, FSM returns to IDLE.
- in_w/in_n values while in_ready=0 have no effect.

## Timing
- Reset values: in_ready=0, busy=0, out_valid=0, done=0, out_s=0, out_row=0, all accumulators 0.
- busy=1 from after edge S through the last DRAIN cycle.
- Row r output: out_valid=1, out_row=r during the cycle after edge S+len+ROW+COL+r, for r in 0..ROW-1.
- done=1 only during the cycle with out_row=ROW-1.
- First result latency from start edge: len+ROW+COL cycles.
- Total busy cycles: len+ROW+COL+ROW-1.
- A new start is accepted on the first edge where the FSM is back in IDLE, i.e. the edge after the done cycle ends.
- No back-to-back overlap of jobs.
- Reset asserted mid-operation: asynchronous return to IDLE, all outputs to reset values, partial results discarded.
- out_s and out_row hold their last value while out_valid=0. Reset clears them to 0.

## Configuration
- MAC_ARRAY_SAT_EN defined: every accumulate saturates to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1]. Once saturated, an accumulator may move back off the rail with later opposite-sign products.
- MAC_ARRAY_SAT_EN undefined: two's-complement wrap. No saturation logic is synthesised.

## Test plan
- ROW=COL=8, len=1, all A=3, all B=2 → 8 rows with every slice =6. First out_valid at S+17, done at S+24.
- len=8, A=identity (1 on diagonal), B[k][j]=k-j clipped to [-8,7] → out_s row r equals B row r. Rows arrive in order 0..7.
- PSUM_BW=8, len=4, all operands 7 → every slice = -60 without MAC_ARRAY_SAT_EN, =127 with it.
- len=255, all operands -8, PSUM_BW=16 → every slice = 16320. Confirms signed product and 8-bit len.
- start pulsed during LOAD and during DRAIN, and start with len=0 in IDLE → all ignored. Result and timing identical to the unperturbed run. in_ready count = len.
- reset asserted during FLUSH, then a new len=1 job with A=1, B=-1 → outputs all -1. No residue from the aborted job. All outputs are 0 while reset is high.
